// File: rtl/buzzer_scheduler.sv
// Buzzer scheduler: latches alert requests from 4 sources and serves them in
// fixed priority (bit 0 highest) as bursts of i+1 beeps followed by a silent gap.
// Optional feature macro: BUZZER_SCHEDULER_ALARM_EN adds an "alarm" input that
// forces the buzzer on and freezes sequencing while asserted.
module buzzer_scheduler #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned ON_MS   = 100,
    parameter int unsigned OFF_MS  = 100,
    parameter int unsigned GAP_MS  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mute,
`ifdef BUZZER_SCHEDULER_ALARM_EN
    input  logic       alarm,
`endif
    output logic       buzz,
    output logic       busy,
    output logic [1:0] active_id,
    output logic [3:0] ack
);

    localparam int unsigned MAX_MS = (ON_MS > OFF_MS) ?
                                     ((ON_MS > GAP_MS) ? ON_MS : GAP_MS) :
                                     ((OFF_MS > GAP_MS) ? OFF_MS : GAP_MS);
    localparam int unsigned MS_W   = $clog2(MAX_MS + 1);
    localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [MS_W-1:0]  ON_LAST  = MS_W'(ON_MS - 1);
    localparam logic [MS_W-1:0]  OFF_LAST = MS_W'(OFF_MS - 1);
    localparam logic [MS_W-1:0]  GAP_LAST = MS_W'(GAP_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        pending;
    logic [3:0]        pending_next;
    logic [3:0]        grant;
    logic [1:0]        grant_id;
    logic [DIV_W-1:0]  div_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [2:0]        beep_left;
    logic [2:0]        beep_left_next;
    logic [1:0]        active_id_next;
    logic              buzz_next;
    logic              tick;
    logic              dur_last;
    logic              done;
    logic              hold;

`ifdef BUZZER_SCHEDULER_ALARM_EN
    assign hold = alarm;
`else
    assign hold = 1'b0;
`endif

    assign tick = (div_cnt == DIV_LAST);
    assign done = tick & dur_last;

    // Lowest set pending index wins the grant
    always_comb begin
        grant_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                grant_id = 2'(i);
            end
        end
    end

    // Last millisecond of the current state's duration
    always_comb begin
        dur_last = 1'b0;
        case (state)
            S_ON:    dur_last = (ms_cnt == ON_LAST);
            S_OFF:   dur_last = (ms_cnt == OFF_LAST);
            S_GAP:   dur_last = (ms_cnt == GAP_LAST);
            default: dur_last = 1'b0;
        endcase
    end

    // Next-state, grant and burst bookkeeping; frozen entirely while held
    always_comb begin
        state_next     = state;
        beep_left_next = beep_left;
        active_id_next = active_id;
        grant          = 4'b0000;
        if (!hold) begin
            case (state)
                S_IDLE: begin
                    if (pending != 4'b0000) begin
                        grant          = 4'(4'b0001 << grant_id);
                        active_id_next = grant_id;
                        beep_left_next = 3'(grant_id) + 3'd1;
                        state_next     = S_ON;
                    end
                end
                S_ON: begin
                    if (done) begin
                        beep_left_next = beep_left - 3'd1;
                        state_next     = (beep_left > 3'd1) ? S_OFF : S_GAP;
                    end
                end
                S_OFF: begin
                    if (done) begin
                        state_next = S_ON;
                    end
                end
                S_GAP: begin
                    if (done) begin
                        state_next     = S_IDLE;
                        active_id_next = 2'd0;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // New requests win over a same-cycle grant so they are re-queued
    assign pending_next = (pending & ~grant) | req;

    // Buzzer follows the ON state unless muted; alarm overrides both
    assign buzz_next = hold | ((state_next == S_ON) & ~mute);

    // State, pending and burst registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pending   <= 4'b0000;
            beep_left <= 3'd0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            beep_left <= beep_left_next;
        end
    end

    // Tick divider and per-state millisecond counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            ms_cnt  <= '0;
        end else if ((state_next != state) || (state == S_IDLE)) begin
            div_cnt <= '0;
            ms_cnt  <= '0;
        end else if (!hold) begin
            if (tick) begin
                div_cnt <= '0;
                ms_cnt  <= ms_cnt + MS_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            buzz      <= 1'b0;
            busy      <= 1'b0;
            active_id <= 2'd0;
            ack       <= 4'b0000;
        end else begin
            buzz      <= buzz_next;
            busy      <= (state_next != S_IDLE);
            active_id <= active_id_next;
            ack       <= grant;
        end
    end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with CLK_DIV=4, ON_MS=2, OFF_MS=1, GAP_MS=3.
// Define BUZZER_SCHEDULER_ALARM_EN to also exercise the alarm override.
module tb_buzzer_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mute;
    logic       buzz;
    logic       busy;
    logic [1:0] active_id;
    logic [3:0] ack;
`ifdef BUZZER_SCHEDULER_ALARM_EN
    logic       alarm;
`endif

    int checks   = 0;
    int failures = 0;

    buzzer_scheduler #(
        .CLK_DIV(4),
        .ON_MS  (2),
        .OFF_MS (1),
        .GAP_MS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mute     (mute),
`ifdef BUZZER_SCHEDULER_ALARM_EN
        .alarm    (alarm),
`endif
        .buzz     (buzz),
        .busy     (busy),
        .active_id(active_id),
        .ack      (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Follow a burst from its grant sample until busy drops (bounded)
    task automatic run_burst(input logic [1:0] id, output int nb, output int nz,
                             output int np, output int nx);
        logic prev;
        nb = 0; nz = 0; np = 0; nx = 0; prev = 1'b0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (buzz === 1'b1) nz++;
            if (buzz === 1'b1 && prev !== 1'b1) np++;
            prev = buzz;
            if (active_id !== id) nx++;
            if (nb > 1 && ack !== 4'b0000) nx++;
            step();
        end
    endtask

    int nb, nz, np, nx, n, z;

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        mute = 1'b0;
`ifdef BUZZER_SCHEDULER_ALARM_EN
        alarm = 1'b0;
`endif
        step();
        step();
        check("rst_buzz", buzz, 0);
        check("rst_busy", busy, 0);
        check("rst_id",   active_id, 0);
        check("rst_ack",  ack, 0);
        rst = 1'b0;
        step();

        // Single request on bit 0
        req = 4'b0001;
        step();
        req = 4'b0000;
        check("t1_pre_ack",  ack, 0);
        check("t1_pre_busy", busy, 0);
        step();
        check("t1_ack",  ack, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_buzz", buzz, 1);
        check("t1_id",   active_id, 0);
        run_burst(2'd0, nb, nz, np, nx);
        check("t1_busy_cycles", nb, 20);
        check("t1_buzz_cycles", nz, 8);
        check("t1_pulses",      np, 1);
        check("t1_consistency", nx, 0);
        check("t1_end_buzz", buzz, 0);
        check("t1_end_id",   active_id, 0);
        step();

        // Three-beep burst from bit 2
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        check("t2_ack", ack, 4'b0100);
        check("t2_id",  active_id, 2);
        run_burst(2'd2, nb, nz, np, nx);
        check("t2_busy_cycles", nb, 44);
        check("t2_buzz_cycles", nz, 24);
        check("t2_pulses",      np, 3);
        check("t2_consistency", nx, 0);
        check("t2_end_id", active_id, 0);
        step();

        // Priority: bits 1 and 3 together
        req = 4'b1010;
        step();
        req = 4'b0000;
        step();
        check("t3_ack_b1", ack, 4'b0010);
        check("t3_id_b1",  active_id, 1);
        run_burst(2'd1, nb, nz, np, nx);
        check("t3_b1_busy_cycles", nb, 32);
        check("t3_b1_pulses",      np, 2);
        check("t3_b1_consistency", nx, 0);
        check("t3_gap_idle_busy", busy, 0);
        check("t3_gap_idle_ack",  ack, 0);
        step();
        check("t3_ack_b3", ack, 4'b1000);
        check("t3_id_b3",  active_id, 3);
        run_burst(2'd3, nb, nz, np, nx);
        check("t3_b3_busy_cycles", nb, 56);
        check("t3_b3_buzz_cycles", nz, 32);
        check("t3_b3_pulses",      np, 4);
        check("t3_b3_consistency", nx, 0);
        step();

        // Requests while busy and re-queue on a held request
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        check("t4_ack_b1", ack, 4'b0010);
        n = 0; z = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy === 1'b1) n++;
            step();
        end
        req = 4'b0011;
        if (busy === 1'b1) n++;
        step();
        req = 4'b0001;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (ack !== 4'b0000) z++;
            step();
        end
        check("t4_b1_busy_cycles", n, 32);
        check("t4_no_preempt",     z, 0);
        step();
        check("t4_ack_b0_first", ack, 4'b0001);
        req = 4'b0000;
        run_burst(2'd0, nb, nz, np, nx);
        check("t4_b0_first_busy", nb, 20);
        check("t4_b0_first_cons", nx, 0);
        step();
        check("t4_ack_b0_again", ack, 4'b0001);
        run_burst(2'd0, nb, nz, np, nx);
        check("t4_b0_again_busy", nb, 20);
        step();
        check("t4_ack_b1_requeued", ack, 4'b0010);
        check("t4_id_b1_requeued",  active_id, 1);
        run_burst(2'd1, nb, nz, np, nx);
        check("t4_b1_requeued_busy", nb, 32);
        check("t4_b1_requeued_cons", nx, 0);
        z = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ack !== 4'b0000 || busy !== 1'b0) z++;
        end
        check("t4_quiet_after", z, 0);

        // Mute keeps timing but silences the buzzer
        mute = 1'b1;
        req  = 4'b0100;
        step();
        req = 4'b0000;
        step();
        check("t5_mute_ack",  ack, 4'b0100);
        check("t5_mute_buzz", buzz, 0);
        check("t5_mute_busy", busy, 1);
        run_burst(2'd2, nb, nz, np, nx);
        check("t5_mute_busy_cycles", nb, 44);
        check("t5_mute_buzz_cycles", nz, 0);
        mute = 1'b0;
        step();

        // Reset mid-ON with another request pending
        req = 4'b1000;
        step();
        req = 4'b0000;
        step();
        check("t5_ack_b3", ack, 4'b1000);
        step();
        step();
        check("t5_on_buzz", buzz, 1);
        req = 4'b0100;
        step();
        req = 4'b0000;
        rst = 1'b1;
        step();
        check("t5_rst_buzz", buzz, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ack",  ack, 0);
        check("t5_rst_id",   active_id, 0);
        rst = 1'b0;
        z = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ack !== 4'b0000 || busy !== 1'b0 || buzz !== 1'b0) z++;
        end
        check("t5_pending_cleared", z, 0);

`ifdef BUZZER_SCHEDULER_ALARM_EN
        // Alarm held mid-OFF: buzzer forced on, sequencing frozen for 10 cycles
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        check("t6_ack", ack, 4'b0010);
        n = 0; z = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) n++;
            if (buzz === 1'b1) z++;
            step();
        end
        check("t6_pre_alarm_off", buzz, 0);
        alarm = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) n++;
            if (buzz === 1'b1) z++;
            step();
            check("t6_alarm_buzz", buzz, 1);
            check("t6_alarm_ack",  ack, 0);
        end
        alarm = 1'b0;
        if (busy === 1'b1) n++;
        if (buzz === 1'b1) z++;
        step();
        check("t6_resume_buzz", buzz, 0);
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (buzz === 1'b1) z++;
            step();
        end
        check("t6_busy_cycles", n, 42);
        check("t6_buzz_cycles", z, 26);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buzzer_scheduler.md
Name: buzzer_scheduler

Overview:
- Arbitrates one piezo buzzer between 4 alert requesters, e.g. channel-5 mode change, low battery, arm/disarm, RC signal loss.
- Each request is latched, then served in fixed priority as a beep burst. Requester i produces i+1 beeps, followed by a silent gap.
- Sits between the flight-control status logic and the buzzer output pin. Replaces direct single-source buzzer driving.

Parameters:
- CLK_DIV, 50000, clk cycles per 1 ms tick (50 MHz system clock).
- ON_MS, 100, beep-on duration in ticks.
- OFF_MS, 100, inter-beep silence in ticks, within a burst.
- GAP_MS, 500, silence after a burst before the next grant.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  4  alert requests, level-sampled each clk; bit 0 is highest priority.
- mute  in  1  forces buzz low; sequencing continues.
- buzz  out  1  buzzer drive, registered.
- busy  out  1  high in any state other than IDLE.
- active_id  out  2  index of the requester being served; 0 when idle.
- ack  out  4  one-cycle pulse on the bit being granted.

Behaviour:
- Reset (rst=1 at an edge) clears pending, the divider, ms_cnt, beep_left, buzz, busy, active_id and ack, and sets state=IDLE.
- Reset mid-burst aborts at once; buzz is 0 after that edge.
- pending[3:0] register: pending[i] is set at any edge where req[i]=1. It is cleared only when bit i is granted.
- Simultaneous set and grant of the same bit: set wins, so the request is re-queued and served again later.
- Tick divider div_cnt counts 0..CLK_DIV-1. tick=1 when div_cnt==CLK_DIV-1; div_cnt wraps to 0 on tick. div_cnt and ms_cnt both clear on every state change, so each state lasts exactly DUR*CLK_DIV cycles.
- ms_cnt increments on tick. A state is left on the tick where ms_cnt==DUR-1.
- FSM states: IDLE, ON, OFF, GAP.
  - IDLE: if pending!=0, grant the lowest set index g. Clear pending[g], pulse ack[g] for 1 cycle, set active_id=g, beep_left=g+1, go to ON. Otherwise stay in IDLE.
  - ON: duration ON_MS. On exit, beep_left decrements. If beep_left was >1, go to OFF; otherwise go to GAP.
  - OFF: duration OFF_MS, then go to ON.
  - GAP: duration GAP_MS, then go to IDLE. active_id returns to 0 on the IDLE entry edge.
- buzz = (next state==ON) & ~mute, registered, so buzz is high exactly while state==ON.
- Latency: req[i] sampled high at edge k sets pending at k. The grant edge is k+1, where ack, busy and buzz go high, provided the FSM was already in IDLE.
- Requests arriving while busy stay pending. They are served in priority order after GAP, with no pre-emption.
- Back-to-back: the cycle after GAP exits is IDLE. A grant can occur on the next edge, so there is 1 idle cycle minimum between bursts.
- Widths: ms_cnt is sized for max(ON_MS,OFF_MS,GAP_MS); beep_left is 3 bits; div_cnt is sized for CLK_DIV.

Optional Feature:
- Macro: BUZZER_SCHEDULER_ALARM_EN.
- Defined:
  - Adds input port alarm (1 bit, after mute).
  - While alarm=1: buzz=1 regardless of mute. FSM, div_cnt and ms_cnt hold. ack is suppressed. pending still latches new requests.
  - When alarm drops, sequencing resumes from the held state and count. buzz returns to the FSM value on the next edge.
- Not defined: no alarm port and no alarm logic.

Test Plan (all with CLK_DIV=4, ON_MS=2, OFF_MS=1, GAP_MS=3):
- Single request: req[0] is a 1-cycle pulse at edge k. Expect ack[0] at k+1, buzz high for 8 cycles, then GAP for 12 cycles, then busy low. active_id=0 throughout.
- Multi-beep: req[2] pulse. Expect 3 buzz pulses of 8 cycles each, separated by 4-cycle gaps, then a 12-cycle GAP. Total busy time is 44 cycles.
- Priority: req=4'b1010 in one cycle. Expect bit 1 served first (2 beeps) with ack[1]. Bit 3 is granted 1 cycle after bit 1's GAP ends (4 beeps, ack[3]).
- Request while busy / re-queue: during req[1]'s burst, pulse req[1] again and hold req[0] high across the grant edge. Expect req[0] then req[1] served after GAP; req[0] is served again because it was still high on its grant edge.
- Mute and reset: mute=1 during a req[2] burst. Expect buzz=0 while busy and timing unchanged. Assert rst mid-ON: expect buzz=0, busy=0, pending=0 after that edge, and no further ack.
- BUZZER_SCHEDULER_ALARM_EN: alarm held for 10 cycles mid-OFF. Expect buzz=1 for those 10 cycles, then OFF resumes with its remaining count. Total burst length is extended by exactly 10 cycles.
